// File: rtl/switch_debounce.sv
// Dual-channel switch debouncer.
// Each raw switch passes through a two-flop synchronizer. A per-channel STABLE/COUNTING FSM
// then accepts a new level only after CNT_MAX consecutive synchronized samples that differ
// from the current output.
// Optional feature macro: DEBOUNCE_CHANGED_EN adds the Changed output. Changed is a one-cycle
// pulse registered on the same edge on which either Data output updates.
module switch_debounce #(
  parameter int unsigned CNT_MAX = 1000000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic CLK,
  input  logic Reset_n,
  input  logic Sw1,
  input  logic Sw2,
  output logic Data1,
  output logic Data2
`ifdef DEBOUNCE_CHANGED_EN
  ,
  output logic Changed
`endif
);

  typedef enum logic [0:0] {
    StStable,
    StCounting
  } state_e;

  // Count value on which a still-differing sample is accepted.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // Index 0 is channel 1 (Sw1/Data1); index 1 is channel 2 (Sw2/Data2).
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       data_q, data_d;
  state_e           state_q [2];
  state_e           state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  // Two-flop synchronizer for both raw switch inputs.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {Sw2, Sw1};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce FSM: next state, next count and next output level.
  always_comb begin
    data_d = data_q;
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      unique case (state_q[ch])
        StStable: begin
          if (sync2_q[ch] != data_q[ch]) begin
            state_d[ch] = StCounting;
            cnt_d[ch]   = CntOne;
          end else begin
            cnt_d[ch] = '0;
          end
        end
        StCounting: begin
          if (sync2_q[ch] == data_q[ch]) begin
            // Level reverted before it was accepted: drop it as a glitch.
            state_d[ch] = StStable;
            cnt_d[ch]   = '0;
          end else if (cnt_q[ch] == CntLast) begin
            data_d[ch]  = sync2_q[ch];
            state_d[ch] = StStable;
            cnt_d[ch]   = '0;
          end else begin
            cnt_d[ch] = cnt_q[ch] + CntOne;
          end
        end
        default: begin
          state_d[ch] = StStable;
          cnt_d[ch]   = '0;
        end
      endcase
    end
  end

  // FSM state, counters and debounced outputs.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      data_q <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= StStable;
        cnt_q[ch]   <= '0;
      end
    end else begin
      data_q <= data_d;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
    end
  end

  assign Data1 = data_q[0];
  assign Data2 = data_q[1];

`ifdef DEBOUNCE_CHANGED_EN
  logic changed_q, changed_d;

  // A single pulse covers updates on either or both channels.
  always_comb begin
    changed_d = (data_d != data_q);
  end

  // Change pulse register, aligned with the data update edge.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign Changed = changed_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce with CNT_MAX=4, CNT_W=3.
// The reference model tracks the two-sample input delay and the run length of disagreeing
// samples. A level is accepted once the run reaches CNT_MAX.
module tb_switch_debounce;

  localparam int unsigned CNT_MAX = 4;
  localparam int unsigned CNT_W   = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic sw1, sw2;
  logic data1, data2;
`ifdef DEBOUNCE_CHANGED_EN
  logic changed;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  switch_debounce #(
    .CNT_MAX(CNT_MAX),
    .CNT_W  (CNT_W)
  ) u_dut (
    .CLK    (clk),
    .Reset_n(rst_n),
    .Sw1    (sw1),
    .Sw2    (sw2),
    .Data1  (data1),
    .Data2  (data2)
`ifdef DEBOUNCE_CHANGED_EN
    ,
    .Changed(changed)
`endif
  );

  always #5 clk = ~clk;

  // Downstream AND stage fed by the debounced operands.
  logic res_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_q <= 1'b0;
    else        res_q <= data1 & data2;
  end

  // Reference model state.
  logic [1:0] m_s1, m_s2, m_data;
  int         m_run [2];
  logic       m_chg, m_res;

  function automatic void model_reset();
    m_s1   = '0;
    m_s2   = '0;
    m_data = '0;
    m_run[0] = 0;
    m_run[1] = 0;
    m_chg  = 1'b0;
    m_res  = 1'b0;
  endfunction

  function automatic void model_edge(input logic [1:0] sw);
    logic [1:0] acc;
    acc   = '0;
    m_res = &m_data;
    for (int ch = 0; ch < 2; ch++) begin
      if (m_s2[ch] != m_data[ch]) begin
        m_run[ch] = m_run[ch] + 1;
        if (m_run[ch] == int'(CNT_MAX)) begin
          m_data[ch] = m_s2[ch];
          m_run[ch]  = 0;
          acc[ch]    = 1'b1;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    m_chg = |acc;
    m_s2  = m_s1;
    m_s1  = sw;
  endfunction

  // Drive inputs, advance one clock edge and the model, then settle before sampling.
  task automatic step(input logic a, input logic b);
    sw1 = a;
    sw2 = b;
    @(posedge clk);
    model_edge({b, a});
    #1;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({data2, data1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: got %b want 00", {data2, data1});
    end
`ifdef DEBOUNCE_CHANGED_EN
    n_cmp++;
    if (changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_changed: got %b want 0", changed);
    end
`endif
  endtask

  task automatic test_single_rise();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (data1 !== (k >= int'(CNT_MAX) + 1) || data2 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_rise k=%0d: got d1=%b d2=%b want d1=%b d2=0",
                 k, data1, data2, (k >= int'(CNT_MAX) + 1));
      end
`ifdef DEBOUNCE_CHANGED_EN
      n_cmp++;
      if (changed !== (k == int'(CNT_MAX) + 1)) begin
        n_fail++;
        $display("FAIL single_rise_chg k=%0d: got %b want %b", k, changed,
                 (k == int'(CNT_MAX) + 1));
      end
`endif
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 12; k++) begin
      step(k < 3, 1'b0);
      n_cmp++;
      if ({data2, data1} !== 2'b00) begin
        n_fail++;
        $display("FAIL glitch k=%0d: got %b want 00", k, {data2, data1});
      end
`ifdef DEBOUNCE_CHANGED_EN
      n_cmp++;
      if (changed !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch_chg k=%0d: got %b want 0", k, changed);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, pat[k]);
      n_cmp++;
      if (data2 !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_early k=%0d: got %b want 0", k, data2);
      end
    end
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1);
      n_cmp++;
      if (data2 !== (k >= int'(CNT_MAX) + 1) || data2 !== m_data[1]) begin
        n_fail++;
        $display("FAIL bounce k=%0d: got %b want %b", k, data2, (k >= int'(CNT_MAX) + 1));
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b1);
      n_cmp++;
      if ({data2, data1} !== ((k >= int'(CNT_MAX) + 1) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL simul k=%0d: got %b", k, {data2, data1});
      end
      n_cmp++;
      if (res_q !== (k >= int'(CNT_MAX) + 2)) begin
        n_fail++;
        $display("FAIL simul_result k=%0d: got %b want %b", k, res_q, (k >= int'(CNT_MAX) + 2));
      end
`ifdef DEBOUNCE_CHANGED_EN
      n_cmp++;
      if (changed !== (k == int'(CNT_MAX) + 1)) begin
        n_fail++;
        $display("FAIL simul_chg k=%0d: got %b", k, changed);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_count();
    // Counter reaches 2 after the fourth edge with Sw1 held high.
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({data2, data1} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid: got %b want 00", {data2, data1});
    end
    #1 rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if (data1 !== (k >= int'(CNT_MAX) + 1)) begin
        n_fail++;
        $display("FAIL reset_mid_rise k=%0d: got %b want %b", k, data1,
                 (k >= int'(CNT_MAX) + 1));
      end
    end
  endtask

  task automatic test_random();
    logic a, b;
    int   h1, h2;
    a  = 1'b0;
    b  = 1'b0;
    h1 = 0;
    h2 = 0;
    for (int k = 0; k < 600; k++) begin
      if (h1 == 0) begin
        a  = ~a;
        h1 = $urandom_range(1, 2 * CNT_MAX + 2);
      end
      if (h2 == 0) begin
        b  = ~b;
        h2 = $urandom_range(1, 2 * CNT_MAX + 2);
      end
      h1--;
      h2--;
      step(a, b);
      n_cmp++;
      if ({data2, data1} !== m_data) begin
        n_fail++;
        $display("FAIL random_data k=%0d: got %b want %b", k, {data2, data1}, m_data);
      end
      n_cmp++;
      if (res_q !== m_res) begin
        n_fail++;
        $display("FAIL random_result k=%0d: got %b want %b", k, res_q, m_res);
      end
`ifdef DEBOUNCE_CHANGED_EN
      n_cmp++;
      if (changed !== m_chg) begin
        n_fail++;
        $display("FAIL random_chg k=%0d: got %b want %b", k, changed, m_chg);
      end
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sw1   = 1'b0;
    sw2   = 1'b0;
    model_reset();
    #12;
    test_reset();
    rst_n = 1'b1;
    test_single_rise();
    do_reset();
    test_glitch();
    do_reset();
    test_bounce();
    do_reset();
    test_simultaneous();
    do_reset();
    test_reset_mid_count();
    do_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
